// File: rtl/plab4_net_arb_pkg.sv
// plab4_net_arb_pkg: shared constants and helpers for the input-control arbiter.
package plab4_net_arb_pkg;
    localparam int TERM = 0;
    localparam int CW = 1;
    localparam int CCW = 2;
    localparam int SLOT_NBITS = 8;
    function automatic int dom_nbits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/plab4_net_route_compute.sv
// plab4_net_route_compute: per-domain route request from head-flit destination.
module plab4_net_route_compute
    import plab4_net_arb_pkg::*;
#(
    parameter int p_router_id = 0,
    parameter int p_num_routers = 8,
    parameter int p_num_ports = 3,
    parameter logic [p_num_ports-1:0] p_default_reqs = p_num_ports'(1),
    parameter int c_dest_nbits = $clog2(p_num_routers)
)(
    input  logic [c_dest_nbits-1:0] dest,
    input  logic                    val,
    output logic [p_num_ports-1:0]  reqs
);
    logic [c_dest_nbits:0] cw_dist;
    always_comb begin
        cw_dist = (dest >= c_dest_nbits'(p_router_id))
            ? {1'b0, dest} - (c_dest_nbits+1)'(p_router_id)
            : {1'b0, dest} + (c_dest_nbits+1)'(p_num_routers - p_router_id);
        // Equal distance both ways resolves clockwise.
        reqs = !val ? '0
             : (dest == c_dest_nbits'(p_router_id)) ? p_default_reqs
             : (2 * int'(cw_dist) <= p_num_routers) ? p_num_ports'(1) << CW
             : p_num_ports'(1) << CCW;
    end
endmodule

// File: rtl/plab4_net_router_input_ctrl_arb_rr.sv
// plab4_net_router_input_ctrl_arb_rr: round-robin (or strict TDM when
// PLAB4_NET_ARB_TDM_EN is defined) selection among per-domain input buffers.
module plab4_net_router_input_ctrl_arb_rr
    import plab4_net_arb_pkg::*;
#(
    parameter int p_router_id = 0,
    parameter int p_num_routers = 8,
    parameter int p_num_domains = 2,
    parameter int p_num_ports = 3,
    parameter logic [p_num_ports-1:0] p_default_reqs = p_num_ports'(1),
    parameter int p_slot_cycles = 4,
    parameter int c_dest_nbits = $clog2(p_num_routers),
    parameter int c_dom_nbits = dom_nbits(p_num_domains)
)(
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [p_num_domains*c_dest_nbits-1:0] dest,
    input  logic [p_num_domains-1:0]              in_val,
    output logic [p_num_domains-1:0]              in_rdy,
    output logic [p_num_ports-1:0]                reqs,
    input  logic [p_num_ports-1:0]                grants,
    output logic [c_dom_nbits-1:0]                domain
);
    logic [p_num_ports-1:0] r [p_num_domains];
    logic [p_num_domains-1:0] pending;
    logic [c_dom_nbits-1:0] eff;
    logic xfer;

    genvar d;
    generate
        for (d = 0; d < p_num_domains; d++) begin : g_route
            plab4_net_route_compute #(
                .p_router_id    (p_router_id),
                .p_num_routers  (p_num_routers),
                .p_num_ports    (p_num_ports),
                .p_default_reqs (p_default_reqs),
                .c_dest_nbits   (c_dest_nbits)
            ) u_route (
                .dest (dest[d*c_dest_nbits +: c_dest_nbits]),
                .val  (in_val[d]),
                .reqs (r[d])
            );
            assign pending[d] = |r[d];
        end
    endgenerate

    assign xfer = |(r[eff] & grants);

    always_comb begin
        reqs = reset ? '0 : r[eff];
        domain = reset ? '0 : eff;
        in_rdy = '0;
        in_rdy[eff] = xfer & !reset;
    end

`ifdef PLAB4_NET_ARB_TDM_EN
    logic [SLOT_NBITS-1:0] slot_cnt;
    logic [c_dom_nbits-1:0] owner;

    assign eff = owner;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            slot_cnt <= '0;
            owner <= '0;
        end else if (slot_cnt == SLOT_NBITS'(p_slot_cycles - 1)) begin
            slot_cnt <= '0;
            owner <= (owner == c_dom_nbits'(p_num_domains - 1)) ? '0 : owner + 1'b1;
        end else
            slot_cnt <= slot_cnt + 1'b1;
`else
    logic [c_dom_nbits-1:0] ptr, sel, pick;
    logic lock;

    // Scan downward so the nearest pending domain at or after ptr wins.
    always_comb begin
        pick = ptr;
        for (int i = p_num_domains - 1; i >= 0; i--)
            if (pending[c_dom_nbits'((int'(ptr) + i) % p_num_domains)])
                pick = c_dom_nbits'((int'(ptr) + i) % p_num_domains);
    end

    assign eff = lock ? sel : pick;

    // An issued but ungranted request holds the selection until granted or withdrawn.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            ptr <= '0;
            sel <= '0;
            lock <= 1'b0;
        end else begin
            lock <= !xfer && pending[eff];
            if (xfer)
                ptr <= (eff == c_dom_nbits'(p_num_domains - 1)) ? '0 : eff + 1'b1;
            if (!xfer && pending[eff])
                sel <= eff;
        end
`endif
endmodule

// File: tb/tb_plab4_net_router_input_ctrl_arb_rr.sv
// tb_plab4_net_router_input_ctrl_arb_rr: directed checks of the input-control arbiter
// (N=2 domains, 8 routers, router id 0).
module tb_plab4_net_router_input_ctrl_arb_rr;
    logic clk = 1'b0;
    logic reset;
    logic [5:0] dest;
    logic [1:0] in_val, in_rdy;
    logic [2:0] reqs, grants;
    logic domain;
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    plab4_net_router_input_ctrl_arb_rr #(
        .p_router_id    (0),
        .p_num_routers  (8),
        .p_num_domains  (2),
        .p_num_ports    (3),
        .p_default_reqs (3'b001),
        .p_slot_cycles  (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .dest   (dest),
        .in_val (in_val),
        .in_rdy (in_rdy),
        .reqs   (reqs),
        .grants (grants),
        .domain (domain)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        in_val = 2'b11;
        dest = {3'd3, 3'd3};
        grants = 3'b000;
`ifdef PLAB4_NET_ARB_TDM_EN
        in_val = 2'b10;
        grants = 3'b111;
        #2;
        chk("tdm_rst_rdy", in_rdy, 2'b00);
        reset = 1'b0;
        #1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("tdm_rdy_c%0d", k), in_rdy, (k < 4) ? 2'b00 : 2'b10);
            chk($sformatf("tdm_dom_c%0d", k), domain, (k < 4) ? 1'b0 : 1'b1);
            cyc();
        end
`else
        #2;
        chk("rst_reqs", reqs, 3'b000);
        chk("rst_rdy", in_rdy, 2'b00);
        chk("rst_dom", domain, 1'b0);
        grants = 3'b111;
        #1;
        chk("rst_rdy_granted", in_rdy, 2'b00);
        cyc();
        reset = 1'b0;
        #1;
        chk("first_dom", domain, 1'b0);
        chk("first_reqs", reqs, 3'b010);
        chk("first_rdy", in_rdy, 2'b01);
        cyc();
        in_val = 2'b10;
        #1;
        chk("d1_reqs", reqs, 3'b010);
        chk("d1_rdy", in_rdy, 2'b10);
        chk("d1_dom", domain, 1'b1);
        cyc();
        in_val = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("b2b_dom_%0d", k), domain, k[0]);
            chk($sformatf("b2b_rdy_%0d", k), in_rdy, k[0] ? 2'b10 : 2'b01);
            cyc();
        end
        in_val = 2'b01;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("single_dom_%0d", k), domain, 1'b0);
            chk($sformatf("single_rdy_%0d", k), in_rdy, 2'b01);
            cyc();
        end
        grants = 3'b000;
        #1;
        chk("stall_dom_0", domain, 1'b0);
        chk("stall_rdy_0", in_rdy, 2'b00);
        cyc();
        in_val = 2'b11;
        for (int k = 1; k < 3; k++) begin
            #1;
            chk($sformatf("stall_dom_%0d", k), domain, 1'b0);
            chk($sformatf("stall_rdy_%0d", k), in_rdy, 2'b00);
            cyc();
        end
        dest = {3'd3, 3'd0};
        #1;
        chk("route_local", reqs, 3'b001);
        dest = {3'd3, 3'd4};
        #1;
        chk("route_tie_cw", reqs, 3'b010);
        dest = {3'd3, 3'd5};
        #1;
        chk("route_ccw5", reqs, 3'b100);
        dest = {3'd3, 3'd7};
        #1;
        chk("route_ccw7", reqs, 3'b100);
        dest = {3'd3, 3'd3};
        grants = 3'b111;
        #1;
        chk("stall_grant_rdy", in_rdy, 2'b01);
        chk("stall_grant_dom", domain, 1'b0);
        cyc();
        chk("after_stall_dom", domain, 1'b1);
        chk("after_stall_rdy", in_rdy, 2'b10);
        cyc();
        in_val = 2'b10;
        grants = 3'b000;
        #1;
        chk("wd_pre_dom", domain, 1'b1);
        cyc();
        in_val = 2'b01;
        #1;
        chk("wd_dom", domain, 1'b1);
        chk("wd_reqs", reqs, 3'b000);
        chk("wd_rdy", in_rdy, 2'b00);
        cyc();
        chk("wd_release_dom", domain, 1'b0);
        chk("wd_release_reqs", reqs, 3'b010);
        grants = 3'b111;
        cyc();
        in_val = 2'b10;
        grants = 3'b000;
        cyc();
        in_val = 2'b11;
        #1;
        chk("lock_dom", domain, 1'b1);
        reset = 1'b1;
        #1;
        chk("async_rst_dom", domain, 1'b0);
        chk("async_rst_reqs", reqs, 3'b000);
        chk("async_rst_rdy", in_rdy, 2'b00);
        reset = 1'b0;
        #1;
        chk("post_rst_dom", domain, 1'b0);
        chk("post_rst_reqs", reqs, 3'b010);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/plab4_net_router_input_ctrl_arb_rr.md
# plab4_net_router_input_ctrl_arb_rr

Parametrised multi-domain input-control arbiter for one router input port. It accepts `p_num_domains` per-domain input buffers and computes a route request for each. It then selects one domain per cycle and drives the shared `reqs`/`grants` handshake toward the switch allocator. Selection uses a registered round-robin pointer with a hold lock, so choices are deterministic and starvation-free. An optional strict time-division mode provides timing non-interference between security domains.

## Interface
- `p_router_id`, 0: this router's id.
- `p_num_routers`, 8: routers on the ring.
- `p_num_domains`, 2: security domains (buffers) sharing this input; ≥2.
- `p_num_ports`, 3: output ports requested; bit 0 = terminal.
- `p_default_reqs`, 3'b001: request vector used when dest == `p_router_id`.
- `p_slot_cycles`, 4: TDM slot length in cycles; used only with TDM enabled.
- `c_dest_nbits`, $clog2(p_num_routers): derived, not set externally.
- `c_dom_nbits`, max(1,$clog2(p_num_domains)): derived, not set externally.
- `clk` input 1: clock.
- `reset` input 1: asynchronous, active-high reset.
- `dest` input p_num_domains*c_dest_nbits: packed head-flit destination per domain; domain d is at slice d.
- `in_val` input p_num_domains: per-domain valid.
- `in_rdy` output p_num_domains: per-domain ready; at most one bit set (one-hot or zero).
- `reqs` output p_num_ports: request of the selected domain.
- `grants` input p_num_ports: grants from the switch allocator.
- `domain` output c_dom_nbits: index of the selected domain.

## Operation
- Route: each domain computes `r[d]` from `dest[d]` and `in_val[d]`. If `in_val[d]` is 0, `r[d]` = 0. If dest == `p_router_id`, `r[d]` = `p_default_reqs`. Otherwise `r[d]` is the shortest ring direction; a tie goes to the clockwise direction.
- Pending domains: domain d is pending when `r[d]` != 0.
- State:
  - `ptr` holds the round-robin base.
  - `sel` holds the last selected domain.
  - `lock` is 1 while the selected domain waits for a grant.
- Selection:
  - If `lock` = 1, the effective selection is `sel`.
  - If `lock` = 0, the effective selection is the first pending domain at or after `ptr`, in modulo order.
  - If no domain is pending, the effective selection is `ptr`.
- Outputs:
  - `reqs` = `r[eff]`.
  - `domain` = eff.
  - `in_rdy[eff]` = |(`r[eff]` & `grants`).
  - All other `in_rdy` bits are 0.
- Transfer: a transfer occurs when `in_rdy[eff]` = 1. On the next edge, `ptr` <= eff+1, wrapping to 0 after `p_num_domains`-1, and `lock` <= 0.
- Stall: when eff is pending with no grant, `lock` <= 1 and `sel` <= eff. Another domain cannot pre-empt a request that has already been issued.
- Withdraw: if `in_val[sel]` drops while locked, `lock` <= 0 and `ptr` is unchanged.
- No latches. Every output is defined every cycle.

## Timing
- Reset values: `ptr`=0, `sel`=0, `lock`=0. Outputs: `reqs`=0, `in_rdy`=0, `domain`=0 (TDM: owner 0).
- `grants` -> `in_rdy` is a combinational path with zero latency.
- State updates at the edge after a transfer or a stall.
- Reset asserted mid-lock clears state immediately, regardless of grants.
- Back-to-back transfers: with all domains pending and all grants high, `domain` cycles 0,1,…,N-1,0 with one transfer per cycle.
- A single pending domain is granted every cycle; it is not forced to wait its turn.

## Configuration
- Macro: `PLAB4_NET_ARB_TDM_EN`.
- When defined:
  - `slot_cnt` counts 0..`p_slot_cycles`-1. On wrap, `owner` advances modulo `p_num_domains`.
  - The effective selection is always `owner`, and `domain` = `owner`.
  - Non-owner domains never receive `in_rdy`, even when the owner is idle.
  - `lock` and `ptr` are unused.
  - Reset sets `slot_cnt`=0 and `owner`=0.
- When undefined: work-conserving round-robin as described above.

## Structure
- Shared package `plab4_net_arb_pkg`: `c_dom_nbits` helper function, port index constants (`TERM`=0, `CW`=1, `CCW`=2), and TDM slot-counter width.
- One sub-module, instantiated per domain in a generate loop: `plab4_net_route_compute` (dest, val -> reqs).

## Test plan
- Reset with `in_val`=2'b11: `reqs`=0, `in_rdy`=0, `domain`=0 while reset is high; after release, domain 0 is selected first.
- Domain 1 only: `dest`=3, `p_router_id`=0, grants=3'b111 -> `reqs`=3'b010, `in_rdy`=2'b10 in the same cycle, `domain`=1.
- Both domains pending, grants always high, 4 cycles -> `domain` sequence 0,1,0,1 with `in_rdy` alternating.
- Domain 0 selected with grants=0 for 3 cycles while domain 1 becomes pending -> `domain` stays 0. Grant in cycle 4 -> `in_rdy`=2'b01, and the next cycle `domain`=1.
- Assert `reset` while `lock`=1 -> state clears asynchronously; after release, `ptr`=0.
- TDM, N=2, `p_slot_cycles`=4, only domain 1 valid -> `in_rdy`=0 for cycles 0-3 and `in_rdy`=2'b10 for cycles 4-7.
